// File: rtl/ad_pkg.sv
// Shared codes for the ad scheduler: served-ad codes, movie types, FSM state.
// Pure declarations; no logic or latency of its own.
// Used by the classifier, the handshake interface and the top.
package ad_pkg;

  typedef enum logic [1:0] {
    AD_DIEHARD   = 2'b00,
    AD_SAFEHAVEN = 2'b01,
    AD_ESCAPE    = 2'b10,
    AD_LINCOLN   = 2'b11
  } ad_t;

  typedef enum logic [1:0] {
    MT_ACTION   = 2'b00,
    MT_ROMANCE  = 2'b01,
    MT_COMEDY   = 2'b10,
    MT_THRILLER = 2'b11
  } movie_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  // Width of the consecutive-serving run counter.
  localparam int RUN_W = 8;

  // Substitute ad used when the repeat cap is hit: next code, wrapping 11 -> 00.
  function automatic ad_t next_ad(input ad_t a);
    logic [1:0] t;
    t = 2'(a) + 2'd1;
    return ad_t'(t);
  endfunction

endpackage

// File: rtl/ad_scheduler_if.sv
// Viewer-record input and served-ad output handshakes of the ad scheduler.
// No logic; carries valid/ready pairs in both directions.
// slave = scheduler side, master = record source / result sink side.
interface ad_scheduler_if;
  import ad_pkg::*;

  logic       in_valid;
  logic       in_ready;
  logic       in_animated;
  logic       in_female;
  logic [1:0] in_type;

  logic       out_valid;
  logic       out_ready;
  ad_t        out_ad;
  logic       out_capped;

  modport slave (
    input  in_valid, in_animated, in_female, in_type, out_ready,
    output in_ready, out_valid, out_ad, out_capped
  );

  modport master (
    output in_valid, in_animated, in_female, in_type, out_ready,
    input  in_ready, out_valid, out_ad, out_capped
  );

endinterface

// File: rtl/ad_classify.sv
// Maps a viewer record (animated, female, movie type) to the preferred ad.
// Purely combinational, zero latency.
// No handshake; the caller decides when the result is used.
module ad_classify
  import ad_pkg::*;
(
  input  logic       animated,
  input  logic       female,
  input  logic [1:0] movie_type,
  output ad_t        ad
);

  logic is_action;
  logic is_romance;
  logic is_comedy;
  logic is_thriller;

  assign is_action   = (movie_type == MT_ACTION);
  assign is_romance  = (movie_type == MT_ROMANCE);
  assign is_comedy   = (movie_type == MT_COMEDY);
  assign is_thriller = (movie_type == MT_THRILLER);

  // Strict priority: earlier rules win even when later ones also match.
  always_comb begin
    ad = AD_LINCOLN;
    if ((is_action || is_thriller) && !animated && !female) begin
      ad = AD_DIEHARD;
    end else if (is_romance || (female && !is_comedy)) begin
      ad = AD_SAFEHAVEN;
    end else if (animated || is_comedy || is_action) begin
      ad = AD_ESCAPE;
    end
  end

endmodule

// File: rtl/ad_scheduler.sv
// Classifies viewer records, enforces a repeat cap, counts served impressions.
// One cycle from accept to out_valid; single-entry output register.
// in_ready drops while a result is held and out_ready is low.
module ad_scheduler
  import ad_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int CAP   = 3
) (
  input  logic             clk,
  input  logic             reset,
  ad_scheduler_if.slave    io,
  input  logic             clr_counts,
  input  logic [1:0]       cnt_sel,
  output logic [CNT_W-1:0] cnt_value
);

  localparam logic [RUN_W-1:0] CAP_RUN = RUN_W'(CAP);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state;
  ad_t              out_ad_q;
  logic             out_capped_q;
  ad_t              last_ad;
  logic [RUN_W-1:0] run_len;
  logic [CNT_W-1:0] cnt [4];

  ad_t  cls_ad;
  ad_t  srv_ad;
  logic srv_capped;
  logic in_ready;
  logic accept;
  logic fire;

  ad_classify u_classify (
    .animated   (io.in_animated),
    .female     (io.in_female),
    .movie_type (io.in_type),
    .ad         (cls_ad)
  );

  // Output register can take a new record when empty or being drained now.
  assign in_ready      = (state == ST_EMPTY || io.out_ready) && !reset;
  assign accept        = io.in_valid && in_ready;
  // Reset discards a held result: no drain is counted in a reset cycle.
  assign fire          = (state == ST_FULL) && io.out_ready && !reset;

  assign io.in_ready   = in_ready;
  assign io.out_valid  = (state == ST_FULL);
  assign io.out_ad     = out_ad_q;
  assign io.out_capped = out_capped_q;
  assign cnt_value     = cnt[cnt_sel];

  // Substitute the next ad once the same ad has already run CAP times in a row.
  always_comb begin
    srv_capped = (cls_ad == last_ad) && (run_len == CAP_RUN);
    srv_ad     = srv_capped ? next_ad(cls_ad) : cls_ad;
  end

  // Output-stage FSM plus run tracking; result fields load only on accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_EMPTY;
      out_ad_q     <= AD_DIEHARD;
      out_capped_q <= 1'b0;
      last_ad      <= AD_DIEHARD;
      run_len      <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            state <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (!accept && io.out_ready) begin
            state <= ST_EMPTY;
          end
        end
        default: state <= ST_EMPTY;
      endcase

      if (accept) begin
        out_ad_q     <= srv_ad;
        out_capped_q <= srv_capped;
        last_ad      <= srv_ad;
        run_len      <= (srv_ad == last_ad) ? run_len + 1'b1 : RUN_W'(1);
      end
    end
  end

  // Impression counters: clear first, then a coinciding drain still counts once.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      if (clr_counts) begin
        for (int i = 0; i < 4; i++) begin
          cnt[i] <= '0;
        end
      end
      if (fire) begin
        if (clr_counts) begin
          cnt[out_ad_q] <= CNT_W'(1);
        end else if (cnt[out_ad_q] != CNT_MAX) begin
          cnt[out_ad_q] <= cnt[out_ad_q] + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ad_scheduler.sv
// Directed bench for ad_scheduler: classification, cap, backpressure, counters.
// Two instances share all inputs; the second has 2-bit counters for saturation.
// Inputs change 1 time unit after the rising edge, outputs are sampled there.
module tb_ad_scheduler;
  import ad_pkg::*;

  logic       clk;
  logic       reset;
  logic       clr_counts;
  logic [1:0] cnt_sel;
  logic [15:0] cnt_value;
  logic [1:0]  cnt_value2;

  int n_cmp;
  int n_err;

  ad_scheduler_if ifa ();
  ad_scheduler_if ifb ();

  assign ifb.in_valid    = ifa.in_valid;
  assign ifb.in_animated = ifa.in_animated;
  assign ifb.in_female   = ifa.in_female;
  assign ifb.in_type     = ifa.in_type;
  assign ifb.out_ready   = ifa.out_ready;

  ad_scheduler #(.CNT_W(16), .CAP(3)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .io         (ifa),
    .clr_counts (clr_counts),
    .cnt_sel    (cnt_sel),
    .cnt_value  (cnt_value)
  );

  ad_scheduler #(.CNT_W(2), .CAP(3)) u_dut2 (
    .clk        (clk),
    .reset      (reset),
    .io         (ifb),
    .clr_counts (clr_counts),
    .cnt_sel    (cnt_sel),
    .cnt_value  (cnt_value2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic a, input logic f, input logic [1:0] t);
    ifa.in_valid    = v;
    ifa.in_animated = a;
    ifa.in_female   = f;
    ifa.in_type     = t;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 2'b00);
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clr_counts = 1'b0;
    ifa.out_ready = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 2'b00);
    tick();
    tick();
    n_cmp++; if (ifa.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", ifa.out_valid); end
    n_cmp++; if (ifa.out_ad !== AD_DIEHARD) begin n_err++; $display("FAIL reset_out_ad got %b want 00", ifa.out_ad); end
    n_cmp++; if (ifa.out_capped !== 1'b0) begin n_err++; $display("FAIL reset_out_capped got %b want 0", ifa.out_capped); end
    n_cmp++; if (ifa.in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got %b want 0", ifa.in_ready); end
    for (int s = 0; s < 4; s++) begin
      cnt_sel = 2'(s);
      #1;
      n_cmp++; if (cnt_value !== 16'd0) begin n_err++; $display("FAIL reset_cnt[%0d] got %0d want 0", s, cnt_value); end
    end
    reset = 1'b0;
    #1;
    n_cmp++; if (ifa.in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready got %b want 1", ifa.in_ready); end
  endtask

  task automatic test_classify();
    logic [1:0] exp_ad [16];
    logic [15:0] exp_cnt [4];
    exp_ad = '{2'b00, 2'b01, 2'b10, 2'b00,
               2'b01, 2'b01, 2'b10, 2'b01,
               2'b10, 2'b01, 2'b10, 2'b10,
               2'b01, 2'b01, 2'b10, 2'b01};
    exp_cnt = '{16'd2, 16'd8, 16'd6, 16'd0};
    pulse_reset();
    ifa.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, i[3], i[2], i[1:0]);
      tick();
      n_cmp++; if (ifa.out_valid !== 1'b1 || ifa.out_ad !== exp_ad[i] || ifa.out_capped !== 1'b0) begin
        n_err++; $display("FAIL classify[A%0d F%0d T%0d] got v=%b ad=%b cap=%b want v=1 ad=%b cap=0",
                          i[3], i[2], i[1:0], ifa.out_valid, ifa.out_ad, ifa.out_capped, exp_ad[i]);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 2'b00);
    tick();
    n_cmp++; if (ifa.out_valid !== 1'b0) begin n_err++; $display("FAIL classify_drain got %b want 0", ifa.out_valid); end
    for (int s = 0; s < 4; s++) begin
      cnt_sel = 2'(s);
      #1;
      n_cmp++; if (cnt_value !== exp_cnt[s]) begin n_err++; $display("FAIL classify_cnt[%0d] got %0d want %0d", s, cnt_value, exp_cnt[s]); end
    end
  endtask

  task automatic test_cap();
    logic [1:0] exp_ad [5];
    logic       exp_cap [5];
    exp_ad  = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00};
    exp_cap = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    pulse_reset();
    ifa.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b0, 2'b00);
      tick();
      n_cmp++; if (ifa.out_ad !== exp_ad[i] || ifa.out_capped !== exp_cap[i]) begin
        n_err++; $display("FAIL cap[%0d] got ad=%b cap=%b want ad=%b cap=%b", i, ifa.out_ad, ifa.out_capped, exp_ad[i], exp_cap[i]);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 2'b00);
    tick();
  endtask

  task automatic test_backpressure();
    pulse_reset();
    ifa.out_ready = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 2'b01);
    tick();
    drive(1'b1, 1'b0, 1'b0, 2'b00);
    cnt_sel = 2'b01;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_cmp++; if (ifa.in_ready !== 1'b0 || ifa.out_valid !== 1'b1 || ifa.out_ad !== AD_SAFEHAVEN || cnt_value !== 16'd0) begin
        n_err++; $display("FAIL hold[%0d] got rdy=%b v=%b ad=%b cnt=%0d want rdy=0 v=1 ad=01 cnt=0",
                          k, ifa.in_ready, ifa.out_valid, ifa.out_ad, cnt_value);
      end
      tick();
    end
    ifa.out_ready = 1'b1;
    #1;
    n_cmp++; if (ifa.in_ready !== 1'b1) begin n_err++; $display("FAIL release_in_ready got %b want 1", ifa.in_ready); end
    tick();
    n_cmp++; if (ifa.out_valid !== 1'b1 || ifa.out_ad !== AD_DIEHARD || cnt_value !== 16'd1) begin
      n_err++; $display("FAIL release_swap got v=%b ad=%b cnt01=%0d want v=1 ad=00 cnt01=1", ifa.out_valid, ifa.out_ad, cnt_value);
    end
    drive(1'b0, 1'b0, 1'b0, 2'b00);
    tick();
    n_cmp++; if (ifa.out_valid !== 1'b0 || cnt_value !== 16'd1) begin
      n_err++; $display("FAIL release_drain got v=%b cnt01=%0d want v=0 cnt01=1", ifa.out_valid, cnt_value);
    end
    cnt_sel = 2'b00;
    #1;
    n_cmp++; if (cnt_value !== 16'd1) begin n_err++; $display("FAIL release_cnt00 got %0d want 1", cnt_value); end
  endtask

  task automatic test_saturate();
    logic [1:0] seq_t [7];
    seq_t = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10};
    pulse_reset();
    ifa.out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b0, 1'b0, seq_t[i]);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 2'b00);
    tick();
    cnt_sel = 2'b10;
    #1;
    n_cmp++; if (cnt_value2 !== 2'd3) begin n_err++; $display("FAIL sat_small_cnt10 got %0d want 3", cnt_value2); end
    n_cmp++; if (cnt_value !== 16'd6) begin n_err++; $display("FAIL sat_wide_cnt10 got %0d want 6", cnt_value); end
    cnt_sel = 2'b01;
    #1;
    n_cmp++; if (cnt_value2 !== 2'd1) begin n_err++; $display("FAIL sat_small_cnt01 got %0d want 1", cnt_value2); end
  endtask

  task automatic test_clear();
    logic [15:0] exp_a [4];
    logic [15:0] exp_b [4];
    exp_a = '{16'd0, 16'd1, 16'd0, 16'd0};
    exp_b = '{16'd1, 16'd0, 16'd0, 16'd0};
    pulse_reset();
    ifa.out_ready = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 2'b00);
    tick();
    drive(1'b1, 1'b0, 1'b0, 2'b10);
    tick();
    drive(1'b1, 1'b0, 1'b0, 2'b01);
    tick();
    drive(1'b0, 1'b0, 1'b0, 2'b00);
    clr_counts = 1'b1;
    tick();
    clr_counts = 1'b0;
    n_cmp++; if (ifa.out_valid !== 1'b0) begin n_err++; $display("FAIL clr_fsm got v=%b want 0", ifa.out_valid); end
    for (int s = 0; s < 4; s++) begin
      cnt_sel = 2'(s);
      #1;
      n_cmp++; if (cnt_value !== exp_a[s]) begin n_err++; $display("FAIL clr_hs_cnt[%0d] got %0d want %0d", s, cnt_value, exp_a[s]); end
    end
    // Run of three 00s; clear lands on the third drain while a fourth 00 is accepted.
    drive(1'b1, 1'b0, 1'b0, 2'b00);
    tick();
    tick();
    tick();
    clr_counts = 1'b1;
    tick();
    clr_counts = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 2'b00);
    n_cmp++; if (ifa.out_ad !== AD_SAFEHAVEN || ifa.out_capped !== 1'b1) begin
      n_err++; $display("FAIL clr_keeps_run got ad=%b cap=%b want ad=01 cap=1", ifa.out_ad, ifa.out_capped);
    end
    for (int s = 0; s < 4; s++) begin
      cnt_sel = 2'(s);
      #1;
      n_cmp++; if (cnt_value !== exp_b[s]) begin n_err++; $display("FAIL clr_run_cnt[%0d] got %0d want %0d", s, cnt_value, exp_b[s]); end
    end
    tick();
    cnt_sel = 2'b01;
    #1;
    n_cmp++; if (ifa.out_valid !== 1'b0 || cnt_value !== 16'd1) begin
      n_err++; $display("FAIL clr_after_drain got v=%b cnt01=%0d want v=0 cnt01=1", ifa.out_valid, cnt_value);
    end
  endtask

  task automatic test_reset_mid();
    ifa.out_ready = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 2'b10);
    tick();
    drive(1'b0, 1'b0, 1'b0, 2'b00);
    n_cmp++; if (ifa.out_valid !== 1'b1 || ifa.out_ad !== AD_ESCAPE) begin
      n_err++; $display("FAIL mid_full got v=%b ad=%b want v=1 ad=10", ifa.out_valid, ifa.out_ad);
    end
    reset = 1'b1;
    ifa.out_ready = 1'b1;
    #1;
    n_cmp++; if (ifa.in_ready !== 1'b0) begin n_err++; $display("FAIL mid_in_ready got %b want 0", ifa.in_ready); end
    tick();
    reset = 1'b0;
    n_cmp++; if (ifa.out_valid !== 1'b0) begin n_err++; $display("FAIL mid_out_valid got %b want 0", ifa.out_valid); end
    for (int s = 0; s < 4; s++) begin
      cnt_sel = 2'(s);
      #1;
      n_cmp++; if (cnt_value !== 16'd0) begin n_err++; $display("FAIL mid_cnt[%0d] got %0d want 0", s, cnt_value); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    cnt_sel = 2'b00;
    clr_counts = 1'b0;
    reset = 1'b1;
    ifa.out_ready = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 2'b00);
    test_reset();
    test_classify();
    test_cap();
    test_backpressure();
    test_saturate();
    test_clear();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
